// File: rtl/elevator_pkg.sv
// Shared elevator types: door encoding, travel direction and car FSM states.
package elevator_pkg;

  typedef enum logic [1:0] {
    DOOR_OPEN    = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_CLOSED  = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_e;

  // Encoded so that the enum value equals the dir_up output bit.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_OPENING = 3'd2,
    ST_OPEN    = 3'd3,
    ST_CLOSING = 3'd4
  } car_state_e;

  // Door value reported for each car state; IDLE and MOVE keep the door shut.
  function automatic door_e door_of(input car_state_e st);
    door_e d;
    d = DOOR_CLOSED;
    case (st)
      ST_OPENING: d = DOOR_OPENING;
      ST_OPEN:    d = DOOR_OPEN;
      ST_CLOSING: d = DOOR_CLOSING;
      default:    d = DOOR_CLOSED;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/elevator_car_fsm_if.sv
// Car <-> dispatcher handshake: stop/continue requests in, floor-step pulses out.
interface elevator_car_fsm_if;
  logic stop_next;
  logic continue_in;
  logic inc;
  logic dec;

  modport master (output stop_next, output continue_in, input inc, input dec);
  modport slave  (input stop_next, input continue_in, output inc, output dec);
endinterface

// File: rtl/elevator_req_scan.sv
// Combinational scan: is any request bit strictly above / below a floor.
module elevator_req_scan #(
  parameter int unsigned FLOORS  = 4,
  parameter int unsigned FLOOR_W = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0]  req,
  input  logic [FLOOR_W-1:0] loc,
  output logic               above_c,
  output logic               below_c
);

  // OR-reduce request bits on either side of loc.
  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (FLOOR_W'(i) > loc)) above_c = 1'b1;
      if (req[i] && (FLOOR_W'(i) < loc)) below_c = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_car_fsm.sv
// Single elevator car controller: button latch, direction choice, travel and door sequencing.
module elevator_car_fsm
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS        = 4,
  parameter int unsigned FLOOR_W       = $clog2(FLOORS),
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned TRAVEL_CYCLES = 3,
  parameter int unsigned INIT_FLOOR    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FLOORS-1:0]   car_call,
  input  logic                obstruct,
  input  logic                hold,
  elevator_car_fsm_if.slave   disp,
  output logic [FLOOR_W-1:0]  location,
  output logic                dir_up,
  output logic [1:0]          door_state,
  output logic                moving,
  output logic [FLOORS-1:0]   buttons
);

  localparam int unsigned DWELL_W  = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int unsigned TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR  = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0]  RST_FLOOR  = FLOOR_W'(INIT_FLOOR);
  localparam logic [DWELL_W-1:0]  DWELL_LD   = DWELL_W'(DOOR_CYCLES - 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LD  = TRAVEL_W'(TRAVEL_CYCLES - 1);

  car_state_e           state_q, state_d;
  logic [FLOOR_W-1:0]   loc_q, loc_d;
  dir_e                 dir_q, dir_d;
  logic [FLOORS-1:0]    buttons_q, buttons_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [TRAVEL_W-1:0]  travel_q, travel_d;

  logic                 arrive_c;
  logic [FLOOR_W-1:0]   tgt_c;
  logic [FLOOR_W-1:0]   scan_loc_c;
  logic                 above_c, below_c;
  dir_e                 dir_eval_c;
  logic                 demand_c;
  logic                 open_next_c;
  logic                 inc_c, dec_c;

  // Direction rule: end floors force the way out, otherwise flip only when nothing lies ahead.
  function automatic dir_e next_dir(input logic [FLOOR_W-1:0] f, input dir_e d,
                                    input logic ab, input logic be, input logic cont);
    dir_e r;
    r = d;
    if (f == TOP_FLOOR)                       r = DIR_DOWN;
    else if (f == '0)                         r = DIR_UP;
    else if ((d == DIR_UP) && !ab && !cont)   r = DIR_DOWN;
    else if ((d == DIR_DOWN) && !be && !cont) r = DIR_UP;
    return r;
  endfunction

  // Arrival happens on the last travel cycle; the target is one floor in the current direction.
  always_comb begin
    arrive_c   = (state_q == ST_MOVE) && (travel_q == '0);
    tgt_c      = (dir_q == DIR_UP) ? (loc_q + FLOOR_W'(1)) : (loc_q - FLOOR_W'(1));
    scan_loc_c = arrive_c ? tgt_c : loc_q;
  end

  // Button latch: accumulate calls, clear the served floor while the door opens, add dispatcher stops.
  always_comb begin
    buttons_d = buttons_q | car_call;
    if ((state_q == ST_OPENING) || (state_q == ST_OPEN)) buttons_d[loc_q] = 1'b0;
    if (disp.stop_next) begin
      if ((dir_q == DIR_UP) && (loc_q != TOP_FLOOR))        buttons_d[loc_q + FLOOR_W'(1)] = 1'b1;
      else if ((dir_q == DIR_DOWN) && (loc_q != '0))        buttons_d[loc_q - FLOOR_W'(1)] = 1'b1;
    end
  end

  elevator_req_scan #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_scan (
    .req     (buttons_d),
    .loc     (scan_loc_c),
    .above_c (above_c),
    .below_c (below_c)
  );

  // Direction and remaining demand as seen from the current (or arriving) floor.
  always_comb begin
    dir_eval_c  = next_dir(scan_loc_c, dir_q, above_c, below_c, disp.continue_in);
    demand_c    = (dir_eval_c == DIR_UP) ? (above_c || disp.continue_in)
                                         : (below_c || disp.continue_in);
    open_next_c = arrive_c && buttons_d[tgt_c];
  end

  // Next-state and counter logic for the car FSM.
  always_comb begin
    state_d  = state_q;
    loc_d    = loc_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
    travel_d = travel_q;
    inc_c    = 1'b0;
    dec_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dir_d = dir_eval_c;
        if (buttons_d[loc_q]) begin
          state_d = ST_OPENING;
        end else if (!hold && demand_c) begin
          state_d  = ST_MOVE;
          travel_d = TRAVEL_LD;
        end
      end
      ST_MOVE: begin
        if (!arrive_c) begin
          travel_d = travel_q - TRAVEL_W'(1);
        end else begin
          inc_c = (dir_q == DIR_UP);
          dec_c = (dir_q == DIR_DOWN);
          loc_d = tgt_c;
          dir_d = dir_eval_c;
          if (open_next_c) begin
            state_d = ST_OPENING;
          end else if (demand_c) begin
            travel_d = TRAVEL_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPENING: begin
        state_d = ST_OPEN;
        dwell_d = DWELL_LD;
      end
      ST_OPEN: begin
        if (obstruct || hold) begin
          dwell_d = DWELL_LD;
        end else if (dwell_q == '0) begin
          state_d = ST_CLOSING;
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      ST_CLOSING: begin
        if (obstruct || car_call[loc_q]) state_d = ST_OPENING;
        else                             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      loc_q     <= RST_FLOOR;
      dir_q     <= DIR_UP;
      buttons_q <= '0;
      dwell_q   <= '0;
      travel_q  <= '0;
    end else begin
      state_q   <= state_d;
      loc_q     <= loc_d;
      dir_q     <= dir_d;
      buttons_q <= buttons_d;
      dwell_q   <= dwell_d;
      travel_q  <= travel_d;
    end
  end

  // Outputs decoded from registered state; step pulses coincide with the arrival edge.
  assign disp.inc   = inc_c;
  assign disp.dec   = dec_c;
  assign location   = loc_q;
  assign dir_up     = (dir_q == DIR_UP);
  assign door_state = door_of(state_q);
  assign moving     = (state_q == ST_MOVE);
  assign buttons    = buttons_q;

endmodule

// File: tb/tb_elevator_car_fsm.sv
// Directed bench for elevator_car_fsm (FLOORS=4, DOOR_CYCLES=4, TRAVEL_CYCLES=3, INIT_FLOOR=0).
module tb_elevator_car_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] car_call = 4'd0;
  logic       obstruct = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] location;
  logic       dir_up;
  logic [1:0] door_state;
  logic       moving;
  logic [3:0] buttons;
  logic [9:0] snap;

  int checks = 0;
  int failures = 0;

  elevator_car_fsm_if disp_if ();

  elevator_car_fsm #(
    .FLOORS        (4),
    .FLOOR_W       (2),
    .DOOR_CYCLES   (4),
    .TRAVEL_CYCLES (3),
    .INIT_FLOOR    (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .car_call   (car_call),
    .obstruct   (obstruct),
    .hold       (hold),
    .disp       (disp_if.slave),
    .location   (location),
    .dir_up     (dir_up),
    .door_state (door_state),
    .moving     (moving),
    .buttons    (buttons)
  );

  always #5 clk = ~clk;

  // {location, door_state, moving, buttons, inc, dec}
  assign snap = {location, door_state, moving, buttons, disp_if.inc, disp_if.dec};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    disp_if.stop_next   = 1'b0;
    disp_if.continue_in = 1'b0;

    // Reset and quiet idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_snap", 32'(snap), 32'({2'd0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0}));
    check_eq("rst_dir", 32'(dir_up), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("idle_quiet", 32'(snap), 32'({2'd0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0}));
      tick();
    end

    // Call to floor 3 from floor 0
    car_call = 4'b1000;
    tick();
    car_call = 4'd0;
    check_eq("up_moving", 32'(moving), 32'd1);
    check_eq("up_btn", 32'(buttons), 32'h8);
    check_eq("up_dir", 32'(dir_up), 32'd1);
    for (int f = 1; f <= 3; f++) begin
      check_eq("up_inc_t2", 32'(disp_if.inc), 32'd0);
      tick();
      check_eq("up_inc_t1", 32'(disp_if.inc), 32'd0);
      tick();
      check_eq("up_inc_t0", 32'({disp_if.inc, disp_if.dec}), 32'b10);
      tick();
      check_eq("up_loc", 32'(location), 32'(f));
    end
    check_eq("top_opening", 32'(door_state), 32'd1);
    check_eq("top_dir", 32'(dir_up), 32'd0);
    check_eq("top_btn_opening", 32'(buttons), 32'h8);
    tick();
    check_eq("top_open", 32'(door_state), 32'd0);
    check_eq("top_btn_clr", 32'(buttons), 32'h0);
    ticks(3);
    check_eq("top_open_last", 32'(door_state), 32'd0);
    tick();
    check_eq("top_closing", 32'(door_state), 32'd3);
    tick();
    check_eq("top_idle", 32'({door_state, moving}), 32'({2'd2, 1'b0}));

    // Down to floor 1
    car_call = 4'b0010;
    tick();
    car_call = 4'd0;
    check_eq("dn_moving", 32'({moving, dir_up}), 32'b10);
    ticks(2);
    check_eq("dn_dec", 32'({disp_if.inc, disp_if.dec}), 32'b01);
    tick();
    check_eq("dn_loc2", 32'(location), 32'd2);
    ticks(2);
    check_eq("dn_dec2", 32'({disp_if.inc, disp_if.dec}), 32'b01);
    tick();
    check_eq("dn_arrive", 32'({location, door_state, dir_up}), 32'({2'd1, 2'd1, 1'b1}));
    ticks(6);
    check_eq("f1_idle", 32'(door_state), 32'd2);

    // continue_in departs up, stop_next stops at floor 2
    disp_if.continue_in = 1'b1;
    tick();
    disp_if.continue_in = 1'b0;
    check_eq("cont_move", 32'({moving, dir_up}), 32'b11);
    disp_if.stop_next = 1'b1;
    tick();
    disp_if.stop_next = 1'b0;
    check_eq("stop_btn", 32'(buttons), 32'h4);
    tick();
    check_eq("stop_inc", 32'(disp_if.inc), 32'd1);
    tick();
    check_eq("stop_arrive", 32'({location, door_state, dir_up}), 32'({2'd2, 2'd1, 1'b0}));

    // Obstruction extends OPEN, then reopens from CLOSING
    obstruct = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      obstruct = (i < 6);
      check_eq("obst_open", 32'(door_state), 32'd0);
      tick();
    end
    check_eq("obst_closing", 32'(door_state), 32'd3);
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    check_eq("obst_reopen", 32'(door_state), 32'd1);
    ticks(6);
    check_eq("f2_idle", 32'({location, door_state, moving}), 32'({2'd2, 2'd2, 1'b0}));

    // Hold keeps the car parked, release moves it down
    hold = 1'b1;
    car_call = 4'b0001;
    tick();
    car_call = 4'd0;
    check_eq("hold_btn", 32'(buttons), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_idle", 32'(moving), 32'd0);
      tick();
    end
    hold = 1'b0;
    tick();
    check_eq("rel_move", 32'({moving, dir_up}), 32'b10);
    ticks(2);
    check_eq("rel_dec", 32'({disp_if.inc, disp_if.dec}), 32'b01);
    tick();
    check_eq("rel_loc1", 32'(location), 32'd1);
    ticks(2);
    check_eq("rel_dec2", 32'({disp_if.inc, disp_if.dec}), 32'b01);
    tick();
    check_eq("rel_arrive", 32'({location, door_state}), 32'({2'd0, 2'd1}));
    ticks(6);
    check_eq("f0_idle", 32'(door_state), 32'd2);

    // Reset mid-MOVE with travel counter at 1
    car_call = 4'b1000;
    tick();
    car_call = 4'd0;
    check_eq("rm_move", 32'(moving), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_snap", 32'(snap), 32'({2'd0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0}));
    tick();
    check_eq("rm_hold_rst", 32'(snap), 32'({2'd0, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    car_call = 4'b0010;
    tick();
    car_call = 4'd0;
    check_eq("rm_resume", 32'(moving), 32'd1);
    ticks(2);
    check_eq("rm_inc", 32'(disp_if.inc), 32'd1);
    tick();
    check_eq("rm_arrive", 32'({location, door_state}), 32'({2'd1, 2'd1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_car_fsm.md
Name: elevator_car_fsm

Overview:
- Parametrised single-car controller; successor to the fixed 3-floor car model.
- Generalised to FLOORS floors.
- Random door/motion pauses are replaced by deterministic dwell and travel counters.
- Adds door-obstruction reopen and a hold (independent-service) mode.
- Instantiated once per car beside the dispatcher (main_control-style). It exchanges stop_next/continue_in/inc/dec with the dispatcher exactly as cars do today.

Parameters:
- FLOORS, 4, number of floors (>=2); floors numbered 0..FLOORS-1.
- FLOOR_W, $clog2(FLOORS), width of floor indices.
- DOOR_CYCLES, 4, cycles the door stays OPEN before closing (>=1).
- TRAVEL_CYCLES, 3, cycles spent in MOVE per floor (>=1).
- INIT_FLOOR, 0, floor after reset (<FLOORS).

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- car_call, in, FLOORS, in-car button presses; bit i = floor i; level-sampled each cycle.
- stop_next, in, 1, dispatcher demands a stop at the next floor in the current direction.
- continue_in, in, 1, dispatcher has pickups beyond this car in the current direction.
- obstruct, in, 1, door sensor blocked.
- hold, in, 1, keep door open / do not depart.
- inc, out, 1, one-cycle pulse: arrived one floor up.
- dec, out, 1, one-cycle pulse: arrived one floor down.
- location, out, FLOOR_W, current floor.
- dir_up, out, 1, 1=UP, 0=DOWN.
- door_state, out, 2, door encoding: 0=OPEN, 1=OPENING, 2=CLOSED, 3=CLOSING.
- moving, out, 1, car is in MOVE.
- buttons, out, FLOORS, latched car-button requests.

Behaviour:
- Reset (async, rst_n=0):
  - location=INIT_FLOOR, dir_up=1, state IDLE (door CLOSED, moving=0).
  - buttons=0, inc=dec=0; dwell/travel counters=0; open_next=0.
- States: IDLE, MOVE, OPENING, OPEN, CLOSING.
- door_state follows state: IDLE and MOVE report CLOSED; the others report their own door value.
- Button latch, each cycle:
  - buttons |= car_call, except the bit for location while state is OPENING/OPEN, which is forced 0.
  - Then, if stop_next and the next floor exists in dir_up, set the bit for location+1 (UP) or location-1 (DOWN). stop_next wins over clearing.
  - stop_next at the end floor in the travel direction is ignored.
- above = any buttons bit > location; below = any buttons bit < location.
- Direction, evaluated in IDLE and at arrival:
  - location==FLOORS-1 forces DOWN; location==0 forces UP.
  - Otherwise UP flips to DOWN when !above && !continue_in; DOWN flips to UP when !below && !continue_in.
- IDLE:
  - buttons[location] or car_call[location] -> OPENING.
  - Else, if !hold and there is demand in the (updated) direction (above/below or continue_in) -> MOVE, travel counter loaded with TRAVEL_CYCLES-1.
  - Else stay.
- MOVE:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: inc (UP) or dec (DOWN) is driven high combinationally, and location ±1 takes effect at that edge.
  - At arrival, open_next = (target floor button set, or stop_next this cycle) -> OPENING. Otherwise, if demand remains beyond -> stay in MOVE with the counter reloaded. Otherwise -> IDLE.
  - Location never wraps: MOVE is never entered toward a nonexistent floor.
- OPENING: one cycle -> OPEN; dwell counter loaded with DOOR_CYCLES-1.
- OPEN:
  - obstruct or hold reloads the dwell counter.
  - Counter 0 with !obstruct && !hold -> CLOSING.
- CLOSING:
  - obstruct -> OPENING (reopen).
  - A new car_call for the current floor -> OPENING.
  - Otherwise -> IDLE after one cycle.
- Simultaneous events:
  - inc and dec are never both 1.
  - car_call and stop_next for the same floor in one cycle -> bit set.
  - hold does not abort an in-progress MOVE; it takes effect at the next IDLE/OPEN.
- Reset asserted mid-MOVE: returns immediately to the reset state; no inc/dec pulse.

Decomposition:
- Shared package elevator_pkg holds:
  - door_e {OPEN, OPENING, CLOSED, CLOSING} with the fixed encoding above.
  - dir_e {UP, DOWN}.
  - car_state_e {IDLE, MOVE, OPENING, OPEN, CLOSING}.
- The dispatcher reuses these typedefs.
- One natural sub-module: elevator_req_scan, combinational FLOORS-wide above/below computation from buttons and location. The dispatcher reuses it for hall buttons.

Test Plan:
- Reset with INIT_FLOOR=0, no inputs for 20 cycles -> location=0, door_state=2, moving=0, buttons=0, inc=dec=0 throughout.
- car_call=4'b1000 at floor 0 (FLOORS=4, TRAVEL_CYCLES=3) -> MOVE next cycle.
  - inc pulses every 3 cycles.
  - location 1, 2, 3.
  - Door goes OPENING then OPEN at floor 3.
  - buttons[3] clears by OPEN.
  - dir_up=0 once at floor 3.
- Car moving up from floor 1 with stop_next during MOVE -> buttons[2]=1; car stops and opens at floor 2.
- OPEN at floor 2, obstruct held 6 cycles during OPEN -> stays OPEN 6+DOOR_CYCLES cycles. A later obstruct pulse in CLOSING -> OPENING the next cycle.
- hold=1 in IDLE with buttons[0]=1 at floor 2 -> no MOVE. Release hold -> MOVE DOWN; dec pulses; reaches floor 0.
- rst_n low mid-MOVE (counter=1) -> immediate IDLE, location=INIT_FLOOR, no inc/dec pulse; normal operation after release.
